// File: rtl/xor_arbiter_pkg.sv
// Shared types and default sizing for the XOR arbiter.
// Optional feature macro used by the top: XOR_ARBITER_PARITY_EN.
package xor_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/xor_arbiter_rr_select.sv
// Round-robin selector: picks the first active request after last_grant,
// wrapping around, and reports it as a one-hot vector and an index.
module rr_select
    import xor_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDXW  = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDXW-1:0]  grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Offsets 1..N_REQ cover every requester once, ending on last_grant itself.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/xor_arbiter.sv
// Shares one registered XOR unit among N_REQ requesters with round-robin arbitration.
// Define XOR_ARBITER_PARITY_EN to add the registered res_parity output.
module xor_arbiter
    import xor_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    input  logic                       res_ready
`ifdef XOR_ARBITER_PARITY_EN
    ,
    output logic                       res_parity
`endif
);

    localparam int IDXW = $clog2(N_REQ);

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   last_grant_reg;
    logic [IDXW-1:0]   res_id_reg;
    logic [WIDTH-1:0]  res_data_reg;
    logic [N_REQ-1:0]  sel_grant;
    logic [IDXW-1:0]   sel_idx;
    logic              slot_free;
    logic              accept;
    logic [WIDTH-1:0]  sel_a, sel_b;

    rr_select #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_rr_select (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (sel_grant),
        .grant_idx  (sel_idx)
    );

    // A full result register frees up in the same cycle it is consumed.
    assign slot_free = (state_reg == IDLE) || res_ready;
    assign req_ready = (slot_free && rst_n) ? sel_grant : '0;
    assign accept    = |req_ready;

    assign sel_a = req_a[sel_idx*WIDTH +: WIDTH];
    assign sel_b = req_b[sel_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (res_ready && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_reg   <= '0;
            res_id_reg     <= '0;
            last_grant_reg <= IDXW'(N_REQ - 1);
        end else if (accept) begin
            res_data_reg   <= sel_a ^ sel_b;
            res_id_reg     <= sel_idx;
            last_grant_reg <= sel_idx;
        end
    end

`ifdef XOR_ARBITER_PARITY_EN
    logic res_parity_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      res_parity_reg <= 1'b0;
        else if (accept) res_parity_reg <= ^(sel_a ^ sel_b);
    end

    assign res_parity = res_parity_reg;
`endif

    assign res_valid = (state_reg == BUSY);
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed plus randomized checks of xor_arbiter against a transaction-level model.
// Honours XOR_ARBITER_PARITY_EN when the design is built with it.
module tb_xor_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic [W-1:0]     res_data;
    logic [IW-1:0]    res_id;
    logic             res_ready;
`ifdef XOR_ARBITER_PARITY_EN
    logic             res_parity;
`endif

    xor_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready)
`ifdef XOR_ARBITER_PARITY_EN
        ,
        .res_parity (res_parity)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the result slot as a (valid, data, id) record plus the last winner.
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_id;
    int         m_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input bit free, input int last);
        if (!free) return -1;
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_last  = N - 1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".res_valid"}, 64'(res_valid), 64'(m_valid));
        chk({tag, ".res_data"},  64'(res_data),  64'(m_data));
        chk({tag, ".res_id"},    64'(res_id),    64'(m_id));
`ifdef XOR_ARBITER_PARITY_EN
        chk({tag, ".res_parity"}, 64'(res_parity), 64'(^m_data));
`endif
    endtask

    // One clock: drive after the falling edge, check the grant, then the registered result.
    task automatic step(input string tag, input logic [N-1:0] v, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic rr, output logic [N-1:0] seen);
        int g;
        logic [N-1:0] exp_rdy;
        req_valid = v; req_a = a; req_b = b; res_ready = rr;
        #1;
        g = pick(v, !m_valid || rr, m_last);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        seen = req_ready;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = a[g*W +: W] ^ b[g*W +: W];
            m_id    = g;
            m_last  = g;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    logic [N-1:0]   seen;
    logic [N*W-1:0] ra, rb;
    logic [W-1:0]   hold_data;
    logic [IW-1:0]  hold_id;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset.req_ready", 64'(req_ready), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 0.
        step("single", 4'b0001, 32'h0000_00A5, 32'h0000_000F, 1'b1, seen);
        chk("single.grant", 64'(seen), 64'b0001);
        chk("single.data", 64'(res_data), 64'hAA);
        $display("txn single grant=%b data=%h id=%0d", seen, res_data, res_id);

        // All requesters valid: strict rotation 1,2,3,0,... after the single grant to 0.
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom}; rb = {$urandom};
            step("rotate", 4'b1111, ra, rb, 1'b1, seen);
            chk("rotate.order", 64'(seen), 64'(4'b0001 << ((i + 1) % N)));
            chk("rotate.valid", 64'(res_valid), 64'd1);
            $display("txn rotate grant=%b data=%h id=%0d", seen, res_data, res_id);
        end

        // Backpressure: slot full, consumer stalls for three cycles.
        hold_data = res_data; hold_id = res_id;
        for (int i = 0; i < 3; i++) begin
            step("stall", 4'b1111, {$urandom}, {$urandom}, 1'b0, seen);
            chk("stall.grant", 64'(seen), 64'd0);
            chk("stall.hold_data", 64'(res_data), 64'(hold_data));
            chk("stall.hold_id", 64'(res_id), 64'(hold_id));
            $display("txn stall grant=%b data=%h id=%0d", seen, res_data, res_id);
        end
        step("release", 4'b1111, {$urandom}, {$urandom}, 1'b1, seen);
        chk("release.grant", 64'(seen), 64'(4'b0001 << ((int'(hold_id) + 1) % N)));
        $display("txn release grant=%b data=%h id=%0d", seen, res_data, res_id);

        // Skip: steer last_grant to 1, then only 0 and 3 are requesting.
        step("drain", 4'b0000, '0, '0, 1'b1, seen);
        step("to0", 4'b0001, {$urandom}, {$urandom}, 1'b1, seen);
        step("to1", 4'b0010, {$urandom}, {$urandom}, 1'b1, seen);
        chk("skip.setup", 64'(seen), 64'b0010);
        step("skip3", 4'b1001, {$urandom}, {$urandom}, 1'b1, seen);
        chk("skip.first", 64'(seen), 64'b1000);
        step("skip0", 4'b1001, {$urandom}, {$urandom}, 1'b1, seen);
        chk("skip.second", 64'(seen), 64'b0001);
        $display("txn skip grant=%b data=%h id=%0d", seen, res_data, res_id);

        // Parity corner: 0xFF ^ 0x01 on requester 1 (next after 0).
        step("parity", 4'b0010, 32'h0000_FF00, 32'h0000_0100, 1'b1, seen);
        chk("parity.data", 64'(res_data), 64'hFE);
`ifdef XOR_ARBITER_PARITY_EN
        chk("parity.bit", 64'(res_parity), 64'd1);
`endif
        $display("txn parity grant=%b data=%h id=%0d", seen, res_data, res_id);

        // Randomized traffic with random drops and backpressure.
        for (int i = 0; i < 300; i++) begin
            step("rand", 4'($urandom), {$urandom}, {$urandom}, ($urandom_range(0, 3) != 0), seen);
            $display("txn rand grant=%b valid=%0d data=%h id=%0d", seen, res_valid, res_data, res_id);
        end

        // Asynchronous reset while BUSY with a stalled result.
        step("prefill", 4'b0100, 32'h0012_0000, 32'h0034_0000, 1'b0, seen);
        step("holdbusy", 4'b1111, {$urandom}, {$urandom}, 1'b0, seen);
        chk("midreset.busy", 64'(res_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        chk("midreset.req_ready", 64'(req_ready), 64'd0);
        $display("txn midreset valid=%0d data=%h id=%0d", res_valid, res_data, res_id);
        @(negedge clk);
        rst_n = 1'b1;
        step("afterreset", 4'b1111, 32'h0000_00F0, 32'h0000_000F, 1'b1, seen);
        chk("afterreset.grant", 64'(seen), 64'b0001);
        $display("txn afterreset grant=%b data=%h id=%0d", seen, res_data, res_id);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, 4, number of requesters sharing the XOR unit (2..8).
REQ-002 The block SHALL have parameter WIDTH, 8, operand and result width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  N_REQ  per-requester operand-valid.
REQ-006 The block SHALL have port req_a  input  N_REQ*WIDTH  packed operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port req_b  input  N_REQ*WIDTH  packed operand B, same packing.
REQ-008 The block SHALL have port req_ready  output  N_REQ  one-hot-or-zero accept strobe.
REQ-009 The block SHALL have port res_valid  output  1  result register holds an unconsumed result.
REQ-010 The block SHALL have port res_data  output  WIDTH  registered A XOR B of the granted request.
REQ-011 The block SHALL have port res_id  output  $clog2(N_REQ)  index of the requester owning res_data.
REQ-012 The block SHALL have port res_ready  input  1  downstream consumes the result when high with res_valid.

Function
REQ-013 The FSM SHALL have two states: IDLE (result register empty) and BUSY (result register full).
REQ-014 A slot SHALL be free when state is IDLE, or state is BUSY with res_ready high.
REQ-015 When a slot is free and any req_valid is high, exactly one req_ready bit SHALL assert, combinationally, selecting the requester chosen by round-robin; otherwise req_ready SHALL be all zeros.
REQ-016 Round-robin SHALL search from index (last_grant+1) mod N_REQ upward with wrap-around; last_grant SHALL update only on an accepted grant.
REQ-017 On an accept at edge t, res_data, res_id SHALL load at edge t and res_valid SHALL be high in the following cycle (latency 1 cycle).
REQ-018 IDLE->BUSY on accept; BUSY->BUSY on res_ready with a new accept (back-to-back, throughput 1 result/cycle); BUSY->IDLE on res_ready with no request; BUSY holds with res_data/res_id stable while res_ready is low.
REQ-019 A requester whose req_valid drops before being granted SHALL be skipped without stalling others.
REQ-020 With all requesters continuously valid, each SHALL be granted exactly once per N_REQ consecutive accepts.
REQ-021 res_ready while res_valid is low SHALL be ignored.

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE, res_valid=0, res_data=0, res_id=0, last_grant=N_REQ-1 (so requester 0 wins first); req_ready SHALL be 0 while rst_n is low.
REQ-023 Reset asserted while BUSY SHALL discard the pending result without handshake.

Configuration
REQ-024 With macro XOR_ARBITER_PARITY_EN defined, the block SHALL add output res_parity (1 bit) = XOR-reduction of res_data, registered alongside res_data, reset 0; without it the port and its logic SHALL not exist.

Structure
REQ-025 Package xor_arbiter_pkg SHALL hold the state enum (IDLE, BUSY) and default constants for N_REQ and WIDTH.
REQ-026 The round-robin selector SHALL be a sub-module rr_select (inputs request vector, last_grant; outputs one-hot grant and index); the XOR and result register stay in xor_arbiter.

Verification
REQ-027 Reset: rst_n=0 mid-BUSY -> res_valid=0, res_data=0, res_id=0 immediately, req_ready=0.
REQ-028 Single request: req_valid=0001, a=0xA5, b=0x0F, res_ready=1 -> req_ready=0001, next cycle res_valid=1, res_data=0xAA, res_id=0.
REQ-029 All valid, res_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; res_valid continuously high after first accept.
REQ-030 Backpressure: res_ready=0 for 3 cycles while BUSY with req_valid=1111 -> req_ready=0000, res_data/res_id stable; first cycle res_ready=1 -> next requester granted same cycle.
REQ-031 Skip: last_grant=1, req_valid=1001 -> requester 3 granted, then 0.
REQ-032 With XOR_ARBITER_PARITY_EN: a=0xFF, b=0x01 -> res_data=0xFE, res_parity=1.
